// File: rtl/fp_pkg.sv
// Shared floating-point constants for the FP multiplier/divider datapath.
package fp_pkg;

    localparam int EXP_W     = 8;
    localparam int MAN_W     = 23;
    localparam int BIAS      = 127;
    localparam int DIV_STEPS = MAN_W + 2;                 // 1 integer + 24 fraction quotient bits
    localparam int SIG_W     = MAN_W + 1;                 // significand with hidden 1
    localparam int Q_W       = DIV_STEPS;                 // quotient register width
    localparam int REM_W     = MAN_W + 3;                 // remainder holds up to 2*divisor
    localparam int XW        = EXP_W + 2;                 // signed exponent working width
    localparam int CNT_W     = $clog2(DIV_STEPS + 1);

    localparam logic [EXP_W-1:0] EXP_ALL_ONES = {EXP_W{1'b1}};

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Zero has a single encoding: +0 with zero exponent and mantissa.
    function automatic logic is_zero(input logic s,
                                     input logic [EXP_W-1:0] e,
                                     input logic [MAN_W-1:0] m);
        return (s == 1'b0) && (e == {EXP_W{1'b0}}) && (m == {MAN_W{1'b0}});
    endfunction

endpackage

// File: rtl/fp_mant_divider.sv
// Restoring significand divider: one quotient bit per enabled step.
// After DIV_STEPS steps o_q = floor(dividend * 2^(DIV_STEPS-1) / divisor).
module fp_mant_divider
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [SIG_W-1:0] i_dividend,
    input  logic [SIG_W-1:0] i_divisor,
    output logic [Q_W-1:0]   o_q,
    output logic             o_count_done
);

    logic [REM_W-1:0] r_rem;
    logic [SIG_W-1:0] r_dvs;
    logic [Q_W-1:0]   r_q;
    logic [CNT_W-1:0] r_cnt;

    logic [REM_W-1:0] w_dvs_ext;
    logic [REM_W-1:0] w_diff;
    logic [REM_W-1:0] w_rem_sel;
    logic             w_ge;

    // Trial subtraction: keep the difference when it does not go negative.
    always_comb begin
        w_dvs_ext = {2'b00, r_dvs};
        w_ge      = (r_rem >= w_dvs_ext);
        w_diff    = r_rem - w_dvs_ext;
        if (w_ge) begin
            w_rem_sel = w_diff;
        end else begin
            w_rem_sel = r_rem;
        end
    end

    // Load operands, then shift one quotient bit in per step until the count completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem <= {REM_W{1'b0}};
            r_dvs <= {SIG_W{1'b0}};
            r_q   <= {Q_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_rem <= {2'b00, i_dividend};
            r_dvs <= i_divisor;
            r_q   <= {Q_W{1'b0}};
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_step && !o_count_done) begin
            r_rem <= w_rem_sel << 1;
            r_q   <= {r_q[Q_W-2:0], w_ge};
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign o_q          = r_q;
    assign o_count_done = (r_cnt == CNT_W'(DIV_STEPS));

endmodule

// File: rtl/fp_seq_div.sv
// Sequential single-precision divider (x / y) with start/done handshake.
// Fixed latency: start sampled at edge 0, done pulses after edge 27.
module fp_seq_div
    import fp_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             xs,
    input  logic [EXP_W-1:0] xe,
    input  logic [MAN_W-1:0] xm,
    input  logic             ys,
    input  logic [EXP_W-1:0] ye,
    input  logic [MAN_W-1:0] ym,
    output logic             busy,
    output logic             done,
    output logic             out_s,
    output logic [EXP_W-1:0] out_e,
    output logic [MAN_W-1:0] out_m,
    output logic             dz,
    output logic             ovf,
    output logic             unf
);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic             r_sign;
    logic [EXP_W-1:0] r_xe;
    logic [EXP_W-1:0] r_ye;
    logic             r_x_zero;
    logic             r_y_zero;

    logic             w_load;
    logic             w_step;
    logic [Q_W-1:0]   w_q;
    logic             w_cnt_done;

    logic             w_hi;
    logic [MAN_W-1:0] w_man;
    logic [XW-1:0]    w_exp;
    logic             w_exp_ovf;
    logic             w_exp_unf;

    logic             w_res_s;
    logic [EXP_W-1:0] w_res_e;
    logic [MAN_W-1:0] w_res_m;
    logic             w_res_dz;
    logic             w_res_ovf;
    logic             w_res_unf;

    assign w_load = (r_state == ST_IDLE) && start;
    assign w_step = (r_state == ST_DIV);

    fp_mant_divider u_mant_div (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_step       (w_step),
        .i_dividend   ({1'b1, xm}),
        .i_divisor    ({1'b1, ym}),
        .o_q          (w_q),
        .o_count_done (w_cnt_done)
    );

    // Next-state logic: DIV waits for the divider's count, NORM and DONE last one cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_DIV;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (w_cnt_done) begin
                    w_next_state = ST_NORM;
                end else begin
                    w_next_state = ST_DIV;
                end
            end
            ST_NORM: w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Capture sign, exponents and zero detection on the accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign   <= 1'b0;
            r_xe     <= {EXP_W{1'b0}};
            r_ye     <= {EXP_W{1'b0}};
            r_x_zero <= 1'b0;
            r_y_zero <= 1'b0;
        end else if (w_load) begin
            r_sign   <= xs ^ ys;
            r_xe     <= xe;
            r_ye     <= ye;
            r_x_zero <= is_zero(xs, xe, xm);
            r_y_zero <= is_zero(ys, ye, ym);
        end
    end

    // Normalise the quotient (it lies in (0.5, 2)) and form the signed result exponent.
    always_comb begin
        w_hi = w_q[Q_W-1];
        if (w_hi) begin
            w_man = w_q[Q_W-2:1];
        end else begin
            w_man = w_q[Q_W-3:0];
        end
        w_exp = {2'b00, r_xe} - {2'b00, r_ye} + XW'(BIAS)
              - {{(XW-1){1'b0}}, ~w_hi};
        w_exp_ovf = ($signed(w_exp) >= $signed({2'b00, EXP_ALL_ONES}));
        w_exp_unf = ($signed(w_exp) <= $signed({XW{1'b0}}));
    end

    // Special-case priority: divide-by-zero, zero dividend, overflow, underflow, normal.
    always_comb begin
        w_res_s   = 1'b0;
        w_res_e   = {EXP_W{1'b0}};
        w_res_m   = {MAN_W{1'b0}};
        w_res_dz  = 1'b0;
        w_res_ovf = 1'b0;
        w_res_unf = 1'b0;
        if (r_y_zero) begin
            w_res_s  = r_sign;
            w_res_e  = EXP_ALL_ONES;
            w_res_dz = 1'b1;
        end else if (r_x_zero) begin
            w_res_s = 1'b0;
        end else if (w_exp_ovf) begin
            w_res_s   = r_sign;
            w_res_e   = EXP_ALL_ONES;
            w_res_ovf = 1'b1;
        end else if (w_exp_unf) begin
            w_res_unf = 1'b1;
        end else begin
            w_res_s = r_sign;
            w_res_e = w_exp[EXP_W-1:0];
            w_res_m = w_man;
        end
    end

    // Result registers update once per operation and otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_s <= 1'b0;
            out_e <= {EXP_W{1'b0}};
            out_m <= {MAN_W{1'b0}};
            dz    <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else if (r_state == ST_NORM) begin
            out_s <= w_res_s;
            out_e <= w_res_e;
            out_m <= w_res_m;
            dz    <= w_res_dz;
            ovf   <= w_res_ovf;
            unf   <= w_res_unf;
        end
    end

    // Handshake outputs: done marks the DONE cycle, busy covers every non-IDLE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            done <= (r_state == ST_NORM);
            busy <= (w_next_state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_fp_seq_div.sv
// Self-checking bench for fp_seq_div: directed, special, range, random and control scenarios.
module tb_fp_seq_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic        xs, ys;
    logic [7:0]  xe, ye;
    logic [22:0] xm, ym;
    logic        busy, done, out_s, dz, ovf, unf;
    logic [7:0]  out_e;
    logic [22:0] out_m;

    int n_cmp;
    int n_fail;

    localparam int LATENCY = 27;
    localparam int N_VEC   = 15;

    // {x, y} operand words and expected {s,e,m,dz,ovf,unf}
    localparam logic [31:0] VEC_X [N_VEC] = '{
        32'h40C00000, 32'h3F800000, 32'hC0200000,                              // 0..2 directed
        32'h00000000, 32'h3F800000, 32'h00000000, 32'hBF800000, 32'h80800000,  // 3..7 specials
        32'h7F000000, 32'h00800000, 32'hFF000000, 32'h7F000000, 32'h7F000000,  // 8..14 range
        32'h00800000, 32'h00800000
    };
    localparam logic [31:0] VEC_Y [N_VEC] = '{
        32'h40000000, 32'h40400000, 32'h3F000000,
        32'h3F800000, 32'h00000000, 32'h00000000, 32'h00000000, 32'h7F000000,
        32'h00800000, 32'h7F000000, 32'h00800000, 32'h3F800000, 32'h3F000000,
        32'h3F800000, 32'h40000000
    };
    localparam logic [34:0] VEC_R [N_VEC] = '{
        {32'h40400000, 3'b000}, {32'h3EAAAAAA, 3'b000}, {32'hC0A00000, 3'b000},
        {32'h00000000, 3'b000}, {32'h7F800000, 3'b100}, {32'h7F800000, 3'b100},
        {32'hFF800000, 3'b100}, {32'h00000000, 3'b001},
        {32'h7F800000, 3'b010}, {32'h00000000, 3'b001}, {32'hFF800000, 3'b010},
        {32'h7F000000, 3'b000}, {32'h7F800000, 3'b010},
        {32'h00800000, 3'b000}, {32'h00000000, 3'b001}
    };

    fp_seq_div dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .xs    (xs),
        .xe    (xe),
        .xm    (xm),
        .ys    (ys),
        .ye    (ye),
        .ym    (ym),
        .busy  (busy),
        .done  (done),
        .out_s (out_s),
        .out_e (out_e),
        .out_m (out_m),
        .dz    (dz),
        .ovf   (ovf),
        .unf   (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: real-valued division of the significands, truncated, with the
    // exponent range and zero rules applied in priority order.
    function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y);
        longint a, b, q;
        int     e;
        logic [22:0] m;
        logic   s;
        s = x[31] ^ y[31];
        if (y == 32'h0) return {s, 8'hFF, 23'h0, 3'b100};
        if (x == 32'h0) return 35'h0;
        a = longint'({1'b1, x[22:0]});
        b = longint'({1'b1, y[22:0]});
        q = (a <<< 24) / b;
        if (q >= (longint'(1) <<< 24)) begin
            m = 23'(q >>> 1);
            e = int'(x[30:23]) - int'(y[30:23]) + 127;
        end else begin
            m = 23'(q);
            e = int'(x[30:23]) - int'(y[30:23]) + 126;
        end
        if (e >= 255) return {s, 8'hFF, 23'h0, 3'b010};
        if (e <= 0)   return {1'b0, 8'h00, 23'h0, 3'b001};
        return {s, 8'(e), m, 3'b000};
    endfunction

    function automatic logic [34:0] observed();
        return {out_s, out_e, out_m, dz, ovf, unf};
    endfunction

    task automatic scramble_operands();
        xs = 1'($urandom); xe = 8'($urandom); xm = 23'($urandom);
        ys = 1'($urandom); ye = 8'($urandom); ym = 23'($urandom);
    endtask

    // Drive one operation and collect timing/handshake observations.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input int glitch_at, input bit start_on_done,
                          output logic [34:0] res, output int lat,
                          output logic busy_mid, output logic busy_done,
                          output logic done_after, output logic busy_after);
        @(posedge clk); #1;
        {xs, xe, xm} = x;
        {ys, ye, ym} = y;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scramble_operands();
        busy_mid  = busy;
        busy_done = 1'b0;
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) begin
                lat = c;
                busy_done = busy;
                break;
            end
            if (c == glitch_at) begin
                scramble_operands();
                start = 1'b1;
            end
        end
        res = observed();
        if (start_on_done) begin
            scramble_operands();
            start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0;
        xs = 1'b0; xe = 8'h0; xm = 23'h0;
        ys = 1'b0; ye = 8'h0; ym = 23'h0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy, done, observed()} !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h want 0", {busy, done, observed()});
        end
        rst = 1'b0;
    endtask

    task automatic test_table(input string tag, input int lo, input int hi);
        logic [34:0] res;
        int lat;
        logic bm, bd, da, ba;
        for (int i = lo; i <= hi; i++) begin
            run_op(VEC_X[i], VEC_Y[i], -1, 1'b0, res, lat, bm, bd, da, ba);
            n_cmp++;
            if (res !== VEC_R[i]) begin
                n_fail++;
                $display("FAIL %s[%0d] result: got %h want %h", tag, i, res, VEC_R[i]);
            end
            n_cmp++;
            if (lat !== LATENCY) begin
                n_fail++;
                $display("FAIL %s[%0d] latency: got %0d want %0d", tag, i, lat, LATENCY);
            end
            n_cmp++;
            if ({bm, bd, da, ba} !== 4'b1100) begin
                n_fail++;
                $display("FAIL %s[%0d] busy/done shape: got %b want 1100", tag, i, {bm, bd, da, ba});
            end
        end
    endtask

    task automatic test_random();
        logic [34:0] res, exp_r;
        logic [31:0] x, y;
        int lat;
        logic bm, bd, da, ba;
        for (int i = 0; i < 60; i++) begin
            x = $urandom;
            y = $urandom;
            x[30:23] = 8'($urandom_range(0, 254));
            if (i % 2 == 0) y[30:23] = 8'($urandom_range(0, 254));
            else            y[30:23] = 8'(($urandom_range(0, 20) + int'(x[30:23]) + 118) % 255);
            if (i % 15 == 3) x = 32'h0;
            if (i % 15 == 7) y = 32'h0;
            exp_r = model(x, y);
            run_op(x, y, -1, 1'b0, res, lat, bm, bd, da, ba);
            n_cmp++;
            if (res !== exp_r || lat !== LATENCY) begin
                n_fail++;
                $display("FAIL random[%0d] %h/%h: got %h lat %0d want %h lat %0d",
                         i, x, y, res, lat, exp_r, LATENCY);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [34:0] res, exp_r;
        int lat;
        logic bm, bd, da, ba;
        exp_r = model(32'h3F800000, 32'h40400000);
        run_op(32'h3F800000, 32'h40400000, 5, 1'b0, res, lat, bm, bd, da, ba);
        n_cmp++;
        if (res !== exp_r || lat !== LATENCY) begin
            n_fail++;
            $display("FAIL start_while_busy: got %h lat %0d want %h lat %0d", res, lat, exp_r, LATENCY);
        end
        n_cmp++;
        if ({da, ba} !== 2'b00) begin
            n_fail++;
            $display("FAIL start_while_busy restart: got done/busy %b want 00", {da, ba});
        end
    endtask

    task automatic test_back_to_back();
        logic [34:0] res;
        int lat, pulses, busy_cycles;
        logic bm, bd, da, ba;
        run_op(32'h40C00000, 32'h40000000, -1, 1'b1, res, lat, bm, bd, da, ba);
        pulses = 0;
        busy_cycles = int'(ba);
        for (int c = 0; c < 35; c++) begin
            @(posedge clk); #1;
            pulses += int'(done);
            busy_cycles += int'(busy);
        end
        n_cmp++;
        if (pulses !== 0 || busy_cycles !== 0) begin
            n_fail++;
            $display("FAIL start_on_done: got %0d done pulses, %0d busy cycles, want 0 and 0",
                     pulses, busy_cycles);
        end
        n_cmp++;
        if (res !== VEC_R[0]) begin
            n_fail++;
            $display("FAIL start_on_done first result: got %h want %h", res, VEC_R[0]);
        end
    endtask

    task automatic test_reset_midop();
        logic [34:0] res, exp_r;
        int lat, pulses;
        logic bm, bd, da, ba;
        @(posedge clk); #1;
        {xs, xe, xm} = 32'hC0200000;
        {ys, ye, ym} = 32'h3F000000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({busy, done, observed()} !== 37'h0) begin
            n_fail++;
            $display("FAIL reset_midop outputs: got %h want 0", {busy, done, observed()});
        end
        pulses = 0;
        for (int c = 0; c < 35; c++) begin
            @(posedge clk); #1;
            pulses += int'(done) + int'(busy);
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL reset_midop aborted op: got %0d done/busy cycles want 0", pulses);
        end
        exp_r = model(32'hC0200000, 32'h3F000000);
        run_op(32'hC0200000, 32'h3F000000, -1, 1'b0, res, lat, bm, bd, da, ba);
        n_cmp++;
        if (res !== exp_r || lat !== LATENCY) begin
            n_fail++;
            $display("FAIL reset_midop restart: got %h lat %0d want %h lat %0d", res, lat, exp_r, LATENCY);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_table("directed", 0, 2);
        test_table("special", 3, 7);
        test_table("range", 8, 14);
        test_random();
        test_start_while_busy();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
